ball_motion_ctrl: RTL and testbench

BALL_MOTION_CTRL -- requirements
Module: ball_motion_ctrl

---
 rtl/ball_motion_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_ctrl.sv
// Bouncing-ball position controller: holds CPU-programmed position/velocity registers,
// advances them once per VGA frame and pushes the ball extents to the display peripheral.
module ball_motion_ctrl #(
    parameter int HMAX = 255,
    parameter int VMAX = 95
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vs_n,
    input  logic       s_chipselect,
    input  logic       s_write,
    input  logic [2:0] s_address,
    input  logic [7:0] s_writedata,
    output logic       m_chipselect,
    output logic       m_write,
    output logic [2:0] m_address,
    output logic [7:0] m_writedata,
    output logic       busy
);

    localparam logic signed [9:0] HLIM  = 10'(HMAX);
    localparam logic signed [9:0] VLIM  = 10'(VMAX);
    localparam logic [7:0]        HMAX8 = 8'(HMAX);
    localparam logic [7:0]        VMAX8 = 8'(VMAX);

    typedef enum logic [2:0] {IDLE, UPDATE, WR_HS, WR_HE, WR_VS, WR_VE} state_t;

    state_t     state_q, state_d;
    logic       en_q, en_d, force_q, force_d, motion_q, motion_d;
    logic [7:0] dx_q, dx_d, dy_q, dy_d, hsize_q, hsize_d, vsize_q, vsize_d;
    logic [7:0] hpos_q, hpos_d, vpos_q, vpos_d;
    logic [7:0] b_hs_q, b_hs_d, b_he_q, b_he_d, b_vs_q, b_vs_d, b_ve_q, b_ve_d;
    logic       vs1_q, vs1_d, vs2_q, vs2_d, vsp_q, vsp_d;
    logic       m_cs_q, m_cs_d, m_wr_q, m_wr_d, busy_q, busy_d;
    logic [2:0] m_addr_q, m_addr_d;
    logic [7:0] m_data_q, m_data_d;
    logic       frame_evt;
    logic [7:0] hsize_eff, vsize_eff;
    logic [15:0] h_step, v_step;

    function automatic logic [7:0] sat_neg(input logic [7:0] v);
        return (v == 8'h80) ? 8'h7f : (8'd0 - v);
    endfunction

    // Returns {new_pos, new_vel}; with move=0 the position is only clamped into range.
    function automatic logic [15:0] axis_step(input logic [7:0] pos, input logic [7:0] vel,
                                              input logic [7:0] size,
                                              input logic signed [9:0] lim, input logic move);
        logic signed [9:0] dv, n, top;
        logic [7:0] p, v;
        dv  = move ? $signed({{2{vel[7]}}, vel}) : 10'sd0;
        n   = $signed({2'b00, pos}) + dv;
        top = lim - $signed({2'b00, size});
        p   = n[7:0];
        v   = vel;
        if (n < 10'sd0) begin
            p = 8'd0;
            v = move ? sat_neg(vel) : vel;
        end else if (n > top) begin
            p = top[7:0];
            v = move ? sat_neg(vel) : vel;
        end
        return {p, v};
    endfunction

    assign frame_evt = vsp_q & ~vs2_q;
    assign hsize_eff = (hsize_q > HMAX8) ? HMAX8 : hsize_q;
    assign vsize_eff = (vsize_q > VMAX8) ? VMAX8 : vsize_q;
    assign h_step    = axis_step(hpos_q, dx_q, hsize_eff, HLIM, motion_q);
    assign v_step    = axis_step(vpos_q, dy_q, vsize_eff, VLIM, motion_q);

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        force_d  = 1'b0;
        motion_d = motion_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        hsize_d  = hsize_q;
        vsize_d  = vsize_q;
        hpos_d   = hpos_q;
        vpos_d   = vpos_q;
        b_hs_d   = b_hs_q;
        b_he_d   = b_he_q;
        b_vs_d   = b_vs_q;
        b_ve_d   = b_ve_q;
        vs1_d    = vs_n;
        vs2_d    = vs1_q;
        vsp_d    = vs2_q;

        case (state_q)
            IDLE: begin
                // Triggers outside IDLE are simply never looked at, so they drop.
                if (force_q || (frame_evt && en_q)) begin
                    state_d  = UPDATE;
                    motion_d = frame_evt && en_q;
                end
            end
            UPDATE: begin
                hpos_d  = h_step[15:8];
                dx_d    = h_step[7:0];
                vpos_d  = v_step[15:8];
                dy_d    = v_step[7:0];
                b_hs_d  = h_step[15:8];
                b_he_d  = h_step[15:8] + hsize_eff;
                b_vs_d  = v_step[15:8];
                b_ve_d  = v_step[15:8] + vsize_eff;
                state_d = WR_HS;
            end
            WR_HS:   state_d = WR_HE;
            WR_HE:   state_d = WR_VS;
            WR_VS:   state_d = WR_VE;
            WR_VE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // CPU writes are applied last so they override a same-cycle motion update.
        if (s_chipselect && s_write) begin
            case (s_address)
                3'd0: begin
                    en_d    = s_writedata[0];
                    force_d = s_writedata[1];
                end
                3'd1:    dx_d    = s_writedata;
                3'd2:    dy_d    = s_writedata;
                3'd3:    hsize_d = s_writedata;
                3'd4:    vsize_d = s_writedata;
                3'd5:    hpos_d  = s_writedata;
                3'd6:    vpos_d  = s_writedata;
                default: ;
            endcase
        end

        busy_d   = (state_d != IDLE);
        m_cs_d   = 1'b0;
        m_wr_d   = 1'b0;
        m_addr_d = 3'd0;
        m_data_d = 8'd0;
        case (state_d)
            WR_HS: begin m_cs_d = 1'b1; m_wr_d = 1'b1; m_addr_d = 3'd3; m_data_d = b_hs_d; end
            WR_HE: begin m_cs_d = 1'b1; m_wr_d = 1'b1; m_addr_d = 3'd4; m_data_d = b_he_d; end
            WR_VS: begin m_cs_d = 1'b1; m_wr_d = 1'b1; m_addr_d = 3'd5; m_data_d = b_vs_d; end
            WR_VE: begin m_cs_d = 1'b1; m_wr_d = 1'b1; m_addr_d = 3'd6; m_data_d = b_ve_d; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            force_q  <= 1'b0;
            motion_q <= 1'b0;
            dx_q     <= 8'd1;
            dy_q     <= 8'd1;
            hsize_q  <= 8'd20;
            vsize_q  <= 8'd12;
            hpos_q   <= 8'd0;
            vpos_q   <= 8'd0;
            b_hs_q   <= 8'd0;
            b_he_q   <= 8'd0;
            b_vs_q   <= 8'd0;
            b_ve_q   <= 8'd0;
            vs1_q    <= 1'b1;
            vs2_q    <= 1'b1;
            vsp_q    <= 1'b1;
            m_cs_q   <= 1'b0;
            m_wr_q   <= 1'b0;
            m_addr_q <= 3'd0;
            m_data_q <= 8'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            force_q  <= force_d;
            motion_q <= motion_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            hsize_q  <= hsize_d;
            vsize_q  <= vsize_d;
            hpos_q   <= hpos_d;
            vpos_q   <= vpos_d;
            b_hs_q   <= b_hs_d;
            b_he_q   <= b_he_d;
            b_vs_q   <= b_vs_d;
            b_ve_q   <= b_ve_d;
            vs1_q    <= vs1_d;
            vs2_q    <= vs2_d;
            vsp_q    <= vsp_d;
            m_cs_q   <= m_cs_d;
            m_wr_q   <= m_wr_d;
            m_addr_q <= m_addr_d;
            m_data_q <= m_data_d;
            busy_q   <= busy_d;
        end
    end

    assign m_chipselect = m_cs_q;
    assign m_write      = m_wr_q;
    assign m_address    = m_addr_q;
    assign m_writedata  = m_data_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: table of programmed states with hand-computed
// display bursts, plus sequences for dropped triggers, write collisions and mid-burst reset.
module tb_ball_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       vs_n;
    logic       s_chipselect, s_write;
    logic [2:0] s_address;
    logic [7:0] s_writedata;
    logic       m_chipselect, m_write;
    logic [2:0] m_address;
    logic [7:0] m_writedata;
    logic       busy;

    always #10 clk = ~clk;

    ball_motion_ctrl #(.HMAX(255), .VMAX(95)) dut (
        .clk         (clk),
        .reset       (reset),
        .vs_n        (vs_n),
        .s_chipselect(s_chipselect),
        .s_write     (s_write),
        .s_address   (s_address),
        .s_writedata (s_writedata),
        .m_chipselect(m_chipselect),
        .m_write     (m_write),
        .m_address   (m_address),
        .m_writedata (m_writedata),
        .busy        (busy)
    );

    typedef struct {
        logic       prog;
        logic       use_force;
        logic [7:0] hpos, vpos, dx, dy, hsize, vsize;
        int         e_hs, e_he, e_vs, e_ve;
    } vec_t;

    vec_t       vecs[14];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cap_n, busy_len;
    logic [2:0] cap_addr[8];
    logic [7:0] cap_data[8];
    logic       found;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        s_chipselect = 1'b1;
        s_write      = 1'b1;
        s_address    = a;
        s_writedata  = d;
        @(negedge clk);
        s_chipselect = 1'b0;
        s_write      = 1'b0;
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        vs_n = 1'b0;
        @(negedge clk);
        vs_n = 1'b1;
    endtask

    // Records every master write and the number of busy cycles over a fixed window.
    task automatic capture(input int budget);
        cap_n    = 0;
        busy_len = 0;
        for (int i = 0; i < 8; i++) begin
            cap_addr[i] = 3'd0;
            cap_data[i] = 8'd0;
        end
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (m_chipselect && m_write) begin
                if (cap_n < 8) begin
                    cap_addr[cap_n] = m_address;
                    cap_data[cap_n] = m_writedata;
                end
                cap_n++;
            end
            if (busy) busy_len++;
        end
    endtask

    task automatic check_burst(input string tag, input int hs, input int he,
                               input int vs, input int ve);
        int expv[4];
        expv = '{hs, he, vs, ve};
        check({tag, "_nwr"}, cap_n, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_addr%0d", tag, i), int'(cap_addr[i]), 3 + i);
            check($sformatf("%s_data%0d", tag, i), int'(cap_data[i]), expv[i]);
        end
        check({tag, "_busy"}, busy_len, 5);
    endtask

    task automatic program_regs(input logic [7:0] ctrl, input logic [7:0] hp, input logic [7:0] vp,
                                input logic [7:0] dx, input logic [7:0] dy,
                                input logic [7:0] hs, input logic [7:0] vs);
        wr(3'd0, ctrl);
        wr(3'd5, hp);
        wr(3'd6, vp);
        wr(3'd1, dx);
        wr(3'd2, dy);
        wr(3'd3, hs);
        wr(3'd4, vs);
    endtask

    initial begin
        //          prog  force hpos    vpos   dx      dy      hsize  vsize   hs  he   vs  ve
        vecs[0]  = '{1'b1, 1'b0, 8'd10,  8'd5,  8'd3,   8'd2,   8'd20, 8'd12,  13, 33,  7,  19};
        vecs[1]  = '{1'b0, 1'b0, 8'd0,   8'd0,  8'd0,   8'd0,   8'd0,  8'd0,   16, 36,  9,  21};
        vecs[2]  = '{1'b1, 1'b0, 8'd234, 8'd5,  8'd5,   8'd2,   8'd20, 8'd12,  235, 255, 7, 19};
        vecs[3]  = '{1'b0, 1'b0, 8'd0,   8'd0,  8'd0,   8'd0,   8'd0,  8'd0,   230, 250, 9, 21};
        vecs[4]  = '{1'b1, 1'b0, 8'd50,  8'd1,  8'd0,   8'hfc,  8'd20, 8'd12,  50, 70,  0,  12};
        vecs[5]  = '{1'b0, 1'b0, 8'd0,   8'd0,  8'd0,   8'd0,   8'd0,  8'd0,   50, 70,  4,  16};
        vecs[6]  = '{1'b1, 1'b0, 8'd0,   8'd83, 8'd0,   8'h80,  8'd20, 8'd12,  0,  20,  0,  12};
        vecs[7]  = '{1'b0, 1'b0, 8'd0,   8'd0,  8'd0,   8'd0,   8'd0,  8'd0,   0,  20,  83, 95};
        vecs[8]  = '{1'b0, 1'b0, 8'd0,   8'd0,  8'd0,   8'd0,   8'd0,  8'd0,   0,  20,  0,  12};
        vecs[9]  = '{1'b1, 1'b0, 8'd0,   8'd0,  8'd0,   8'd0,   8'd20, 8'd200, 0,  20,  0,  95};
        vecs[10] = '{1'b1, 1'b0, 8'd2,   8'd10, 8'hfb,  8'd0,   8'd20, 8'd12,  0,  20,  10, 22};
        vecs[11] = '{1'b0, 1'b0, 8'd0,   8'd0,  8'd0,   8'd0,   8'd0,  8'd0,   5,  25,  10, 22};
        vecs[12] = '{1'b1, 1'b1, 8'd100, 8'd40, 8'd7,   8'd3,   8'd20, 8'd12,  100, 120, 40, 52};
        vecs[13] = '{1'b1, 1'b1, 8'd250, 8'd90, 8'd7,   8'd3,   8'd20, 8'd12,  235, 255, 83, 95};

        reset        = 1'b1;
        vs_n         = 1'b1;
        s_chipselect = 1'b0;
        s_write      = 1'b0;
        s_address    = 3'd0;
        s_writedata  = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_mcs",   int'(m_chipselect), 0);
        check("rst_mwr",   int'(m_write), 0);
        check("rst_maddr", int'(m_address), 0);
        check("rst_mdata", int'(m_writedata), 0);
        check("rst_busy",  int'(busy), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset defaults show up in the first burst: HPOS=VPOS=0 moved by DX=DY=1.
        wr(3'd0, 8'h01);
        fork frame_pulse(); capture(14); join
        check_burst("rst_def", 1, 21, 1, 13);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].prog)
                program_regs(vecs[i].use_force ? 8'h00 : 8'h01, vecs[i].hpos, vecs[i].vpos,
                             vecs[i].dx, vecs[i].dy, vecs[i].hsize, vecs[i].vsize);
            if (vecs[i].use_force) begin
                fork wr(3'd0, 8'h02); capture(14); join
            end else begin
                fork frame_pulse(); capture(14); join
            end
            check_burst($sformatf("v%0d", i), vecs[i].e_hs, vecs[i].e_he,
                        vecs[i].e_vs, vecs[i].e_ve);
        end

        // EN still 0 after FORCE: a frame must not start a burst.
        fork frame_pulse(); capture(14); join
        check("en0_nwr", cap_n, 0);
        check("en0_busy", busy_len, 0);

        // Second frame edge landing in WR_HE is dropped.
        program_regs(8'h01, 8'd10, 8'd5, 8'd3, 8'd2, 8'd20, 8'd12);
        fork
            begin
                frame_pulse();
                @(negedge clk);
                frame_pulse();
            end
            capture(20);
        join
        check_burst("drop", 13, 33, 7, 19);

        // HPOS written during WR_VS: burst unchanged, next frame starts from 50.
        program_regs(8'h01, 8'd10, 8'd5, 8'd3, 8'd2, 8'd20, 8'd12);
        found = 1'b0;
        fork
            frame_pulse();
            capture(14);
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                if (m_write && m_address == 3'd5) begin
                    s_chipselect = 1'b1; s_write = 1'b1; s_address = 3'd5; s_writedata = 8'd50;
                    @(negedge clk);
                    s_chipselect = 1'b0; s_write = 1'b0;
                    found = 1'b1;
                    break;
                end
            end
        join
        check("wrvs_found", int'(found), 1);
        check_burst("wrvs_cur", 13, 33, 7, 19);
        fork frame_pulse(); capture(14); join
        check_burst("wrvs_next", 53, 73, 9, 21);

        // HPOS written in the UPDATE cycle wins over the computed position.
        found = 1'b0;
        fork
            frame_pulse();
            capture(14);
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                if (busy && !m_write) begin
                    s_chipselect = 1'b1; s_write = 1'b1; s_address = 3'd5; s_writedata = 8'd100;
                    @(negedge clk);
                    s_chipselect = 1'b0; s_write = 1'b0;
                    found = 1'b1;
                    break;
                end
            end
        join
        check("upd_found", int'(found), 1);
        check_burst("upd_cur", 56, 76, 11, 23);
        fork frame_pulse(); capture(14); join
        check_burst("upd_next", 103, 123, 13, 25);

        // Reset during WR_HE clears outputs at once and ends the burst.
        found = 1'b0;
        fork
            frame_pulse();
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                if (m_write && m_address == 3'd4) begin
                    found = 1'b1;
                    break;
                end
            end
        join
        check("mid_found", int'(found), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_mcs",   int'(m_chipselect), 0);
        check("mid_mwr",   int'(m_write), 0);
        check("mid_maddr", int'(m_address), 0);
        check("mid_mdata", int'(m_writedata), 0);
        check("mid_busy",  int'(busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        capture(14);
        check("post_rst_nwr", cap_n, 0);
        wr(3'd0, 8'h01);
        fork frame_pulse(); capture(14); join
        check_burst("post_rst", 1, 21, 1, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
